maxmin_loader: RTL and testbench



---
 rtl/maxmin_loader_pkg.sv | 13 +
 rtl/maxmin_loader_frame_counter.sv | 20 ++
 rtl/maxmin_loader.sv | 77 +++++++
 tb/tb_maxmin_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/maxmin_loader_pkg.sv
// maxmin_loader_pkg: frame geometry and FSM encoding shared by the loader,
// the register file and the max/min engine.
package maxmin_loader_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 256;
  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    COMMIT = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_e;
endpackage

// File: rtl/maxmin_loader_frame_counter.sv
// frame_counter: loadable/clearable up-counter with a terminal-count flag.
module frame_counter #(
  parameter int W    = 9,
  parameter int TERM = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : ld_i ? ld_val_i : inc_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= !rst_ni ? '0 : cnt_d;
  assign cnt_o  = cnt_q;
  assign term_o = cnt_q == W'(TERM);
endmodule

// File: rtl/maxmin_loader.sv
// maxmin_loader: streams one frame into the register file, kicks the max/min
// engine and hands its captured result downstream.
module maxmin_loader
  import maxmin_loader_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              go,
  input  logic              mm_done,
  input  logic [WIDTH-1:0]  mm_max_diff,
  output logic              res_valid,
  output logic [WIDTH-1:0]  res_data,
  input  logic              res_ready,
  output logic              busy
);
  state_e state_q, state_d;
  logic first_q, wr_en_q, acc, at_term;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WIDTH-1:0] wr_data_q, res_q;
  logic [ADDR_W:0] cnt;
  // the counter's top bit can only be set after the final accept, so it also blocks overflow
  assign in_ready = Rst && state_q == LOAD && !cnt[ADDR_W];
  assign acc      = in_valid && in_ready;
  frame_counter #(.W(ADDR_W + 1), .TERM(DEPTH - 1)) u_cnt (
    .clk_i   (Clk),
    .rst_ni  (Rst),
    .clr_i   (state_q == START),
    .ld_i    (1'b0),
    .ld_val_i('0),
    .inc_i   (acc),
    .cnt_o   (cnt),
    .term_o  (at_term)
  );
  // first_q marks the first WAIT cycle, where a stale done from the last run is ignored
  always_comb
    state_d = state_q == LOAD   ? (acc && at_term ? COMMIT : LOAD) :
              state_q == COMMIT ? START :
              state_q == START  ? WAIT :
              state_q == WAIT   ? (!first_q && mm_done ? RESULT : WAIT) :
              state_q == RESULT ? (res_ready ? LOAD : RESULT) : LOAD;
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= LOAD;
      first_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      res_q     <= '0;
    end else begin
      state_q <= state_d;
      first_q <= state_q == START;
      wr_en_q <= acc;
      if (acc) begin
        wr_addr_q <= cnt[ADDR_W-1:0];
        wr_data_q <= in_data;
      end
      if (state_q == WAIT && state_d == RESULT) res_q <= mm_max_diff;
    end
  end
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign go        = state_q == START;
  assign res_valid = state_q == RESULT;
  assign res_data  = res_q;
  assign busy      = state_q != LOAD;
endmodule

// File: tb/tb_maxmin_loader.sv
// tb_maxmin_loader: directed frames with a write scoreboard and engine model.
module tb_maxmin_loader;
  logic       Clk = 0, Rst = 0, in_valid = 0, mm_done = 0, res_ready = 0;
  logic [7:0] in_data = 0, mm_max_diff = 0;
  logic       in_ready, wr_en, go, res_valid, busy;
  logic [7:0] wr_addr, wr_data, res_data;
  int         checks = 0, errors = 0, go_cnt = 0;
  bit         mon_en = 0, pend = 0;
  logic [1:0] go_sr = 0;
  logic [7:0] model_addr = 0, d = 0;
  logic [15:0] wq[$];
  logic [7:0]  rq[$];

  maxmin_loader dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .go(go),
    .mm_done(mm_done), .mm_max_diff(mm_max_diff),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // write-port scoreboard: accepts seen before an edge must appear as wr_en in the next cycle
  always @(negedge Clk) if (mon_en) begin
    logic [15:0] e;
    chk("wr_en", wr_en, pend);
    if (pend) begin
      e = wq.pop_front();
      chk("wr_addr", wr_addr, e[15:8]);
      chk("wr_data", wr_data, e[7:0]);
    end
    chk("go_timing", go, go_sr[1]);
    if (go) go_cnt++;
    if (!Rst) begin
      model_addr = 0;
      pend = 0;
      go_sr = 0;
      wq.delete();
    end else begin
      pend = in_valid && in_ready;
      go_sr = {go_sr[0], pend && model_addr == 8'hFF};
      if (pend) begin
        wq.push_back({model_addr, in_data});
        model_addr++;
      end
    end
  end

  task automatic send(input logic [7:0] v, input bit gap, output int w);
    logic r;
    if (gap) while ($urandom_range(1, 0) == 1) begin in_valid = 0; tick(); end
    in_valid = 1;
    in_data = v;
    w = 0;
    forever begin
      r = in_ready;
      tick();
      w++;
      if (r) break;
      if (w > 1000) begin chk("accept_timeout", 0, 1); break; end
    end
    in_valid = 0;
  endtask

  task automatic send_frame(input int n, input int kind, input bit gaps, input bit b2b,
                            output logic [7:0] diff);
    logic [7:0] mx = 0, mn = 8'hFF, v;
    int w, tot = 0;
    for (int i = 0; i < n; i++) begin
      v = kind == 0 ? 8'(i) : kind == 1 ? (i == 17 ? 8'h05 : 8'hA5) : 8'($urandom);
      send(v, gaps, w);
      if (b2b && i == 0) chk("b2b_first_accept", w, 1);
      tot += w;
      if (v > mx) mx = v;
      if (v < mn) mn = v;
    end
    if (!gaps) chk("no_bubbles", tot, n);
    diff = mx - mn;
  endtask

  task automatic wait_go();
    int n = 0;
    while (go !== 1'b1 && n < 2000) begin tick(); n++; end
    chk("go_seen", go, 1);
  endtask

  task automatic finish(input logic [7:0] diff, input int delay);
    wait_go();
    repeat (delay) tick();
    chk("no_early_res", res_valid, 0);
    mm_max_diff = diff;
    mm_done = 1;
    rq.push_back(diff);
    tick();
    mm_done = 0;
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, rq.pop_front());
  endtask

  task automatic handshake();
    res_ready = 1;
    tick();
    res_ready = 0;
    chk("res_valid_drop", res_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("busy_low", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_go", go, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    mon_en = 1;
    Rst = 1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    // frame 1: ramp data, late done
    go_cnt = 0;
    send_frame(256, 0, 0, 0, d);
    chk("ramp_diff_model", d, 8'hFF);
    finish(d, 300);
    chk("go_once_f1", go_cnt, 1);
    handshake();
    // frame 2: gapped input, then a stalled consumer
    send_frame(256, 1, 1, 0, d);
    finish(d, 7);
    repeat (20) begin
      in_valid = 1'($urandom);
      tick();
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, d);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    handshake();
    // frame 3: stale done held high from the previous run
    mm_done = 1;
    mm_max_diff = 8'hA0;
    go_cnt = 0;
    send_frame(256, 2, 0, 0, d);
    wait_go();
    tick();
    mm_max_diff = d;
    tick();
    chk("stale_done_ignored", res_valid, 0);
    rq.push_back(d);
    tick();
    mm_done = 0;
    chk("stale_res_valid", res_valid, 1);
    chk("stale_res_data", res_data, rq.pop_front());
    chk("go_once_f3", go_cnt, 1);
    handshake();
    // reset after 100 accepts
    send_frame(100, 2, 0, 0, d);
    Rst = 0;
    tick();
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    Rst = 1;
    #1;
    chk("mid_rel_in_ready", in_ready, 1);
    go_cnt = 0;
    send_frame(256, 2, 0, 0, d);
    finish(d, 4);
    chk("go_once_after_rst", go_cnt, 1);
    handshake();
    // two frames back-to-back
    send_frame(256, 2, 0, 0, d);
    finish(d, 3);
    handshake();
    send_frame(256, 2, 0, 1, d);
    finish(d, 3);
    handshake();
    tick();
    chk("wq_drained", 16'(wq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
